// File: rtl/rgb_pwm_capture8.sv
// Receive-side PWM decoder: recovers 8-bit duty values on three colour lines by
// counting active samples over a free-running 256-sample window.
module rgb_pwm_capture8 #(
    parameter int DIV         = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       an,
    input  logic       r_i,
    input  logic       g_i,
    input  logic       b_i,
    output logic [7:0] rcolor_o,
    output logic [7:0] gcolor_o,
    output logic [7:0] bcolor_o,
    output logic       valid,
    output logic       locked,
    output logic       changed
);

    localparam int            PW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PLAST = PW'(DIV - 1);

    logic [PW-1:0]                r_presc;
    logic                         w_tick;
    logic [SYNC_STAGES-1:0][2:0]  r_sync;
    logic [2:0]                   w_active;
    logic [7:0]                   r_winCnt;
    logic                         w_winEnd;
    logic [2:0][8:0]              r_acc;
    logic [2:0][8:0]              w_sum;
    logic [2:0][7:0]              w_color;
    logic [2:0][7:0]              r_color;
    logic                         w_diff;
    logic                         r_seen;
    logic                         r_valid;
    logic                         r_changed;
    logic                         r_locked;

    // Channel index 2 = red, 1 = green, 0 = blue throughout.
    assign w_tick   = (r_presc == PLAST);
    assign w_active = r_sync[SYNC_STAGES-1] ^ {3{an}};
    assign w_winEnd = w_tick && (r_winCnt == 8'hFF);
    assign w_diff   = (w_color != r_color);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_sync  <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            r_sync  <= {r_sync[SYNC_STAGES-2:0], {r_i, g_i, b_i}};
        end
    end

    // A full window of 256 high samples saturates to 255 so constant-high reads as full scale.
    always_comb begin
        w_sum   = '0;
        w_color = '0;
        for (int ch = 0; ch < 3; ch++) begin
            w_sum[ch]   = r_acc[ch] + {8'd0, w_active[ch]};
            w_color[ch] = w_sum[ch][8] ? 8'hFF : w_sum[ch][7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_winCnt <= '0;
            r_acc    <= '0;
        end else if (w_tick) begin
            r_winCnt <= r_winCnt + 8'd1;
            r_acc    <= w_winEnd ? '0 : w_sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_color   <= '0;
            r_valid   <= 1'b0;
            r_changed <= 1'b0;
            r_locked  <= 1'b0;
            r_seen    <= 1'b0;
        end else begin
            r_valid   <= w_winEnd;
            r_changed <= w_winEnd && r_seen && w_diff;
            if (w_winEnd) begin
                r_color <= w_color;
                r_seen  <= 1'b1;
                // The very first window has nothing to compare against, so lock needs a predecessor.
                if (r_seen) begin
                    r_locked <= !w_diff;
                end
            end
        end
    end

    assign rcolor_o = r_color[2];
    assign gcolor_o = r_color[1];
    assign bcolor_o = r_color[0];
    assign valid    = r_valid;
    assign changed  = r_changed;
    assign locked   = r_locked;

endmodule

// File: tb/tb_rgb_pwm_capture8.sv
// Bench for rgb_pwm_capture8: table vectors, corner sequences and a window-count
// reference model fed with randomized PWM stimulus.
module tb_rgb_pwm_capture8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       an  = 1'b0;
    logic       r_i, g_i, b_i;
    logic [7:0] rcolor_o, gcolor_o, bcolor_o;
    logic       valid, locked, changed;

    logic       rstB = 1'b1;
    logic       rB;
    logic [7:0] rcB, gcB, bcB;
    logic       validB, lockedB, changedB;

    int checks = 0;
    int errors = 0;

    rgb_pwm_capture8 #(.DIV(1), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .an(an), .r_i(r_i), .g_i(g_i), .b_i(b_i),
        .rcolor_o(rcolor_o), .gcolor_o(gcolor_o), .bcolor_o(bcolor_o),
        .valid(valid), .locked(locked), .changed(changed)
    );

    rgb_pwm_capture8 #(.DIV(4), .SYNC_STAGES(2)) dutB (
        .clk(clk), .rst(rstB), .an(1'b0), .r_i(rB), .g_i(1'b0), .b_i(1'b0),
        .rcolor_o(rcB), .gcolor_o(gcB), .bcolor_o(bcB),
        .valid(validB), .locked(lockedB), .changed(changedB)
    );

    // PWM sources standing in for the team's driver: 256-phase period, or 1024 clk for the DIV=4 unit.
    logic [7:0] dutyR = 8'h00, dutyG = 8'h00, dutyB = 8'h00;
    logic       invLines = 1'b0;
    int         pwmCnt  = 0;
    int         pwmCntB = 0;

    function automatic logic pwmLevel(input int phase, input logic [7:0] duty);
        return (duty == 8'hFF) || (phase < int'(duty));
    endfunction

    always @(negedge clk) begin
        r_i = invLines ^ pwmLevel(pwmCnt, dutyR);
        g_i = invLines ^ pwmLevel(pwmCnt, dutyG);
        b_i = invLines ^ pwmLevel(pwmCnt, dutyB);
        pwmCnt = rst ? 0 : (pwmCnt + 1) % 256;
        rB = (pwmCntB < 8'h33 * 4);
        pwmCntB = rstB ? 0 : (pwmCntB + 1) % 1024;
    end

    // Reference: each window is 256 consecutive samples; the result is the number of active ones, capped at 255.
    logic [2:0] pipe[$];
    int         cnt[3];
    int         sampleIdx = 0;
    logic [7:0] expColor[3];
    logic       expValid = 1'b0, expChanged = 1'b0, expLocked = 1'b0, seen = 1'b0;

    always @(posedge clk) begin : refModel
        logic [2:0] act;
        logic [7:0] newC[3];
        logic       diff;
        if (rst) begin
            pipe.delete();
            for (int k = 0; k < 2; k++) pipe.push_back(3'b000);
            for (int ch = 0; ch < 3; ch++) begin
                cnt[ch] = 0;
                expColor[ch] = 8'h00;
            end
            sampleIdx = 0;
            expValid = 1'b0; expChanged = 1'b0; expLocked = 1'b0; seen = 1'b0;
        end else begin
            expValid = 1'b0;
            expChanged = 1'b0;
            pipe.push_back({r_i, g_i, b_i});
            act = pipe.pop_front() ^ {3{an}};
            for (int ch = 0; ch < 3; ch++) cnt[ch] += int'(act[2-ch]);
            sampleIdx++;
            if (sampleIdx == 256) begin
                diff = 1'b0;
                for (int ch = 0; ch < 3; ch++) begin
                    newC[ch] = (cnt[ch] > 255) ? 8'hFF : 8'(cnt[ch]);
                    if (newC[ch] != expColor[ch]) diff = 1'b1;
                end
                expValid = 1'b1;
                expChanged = seen && diff;
                if (seen) expLocked = !diff;
                seen = 1'b1;
                for (int ch = 0; ch < 3; ch++) begin
                    expColor[ch] = newC[ch];
                    cnt[ch] = 0;
                end
                sampleIdx = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    logic modelOn = 1'b0;
    always @(negedge clk) begin
        if (modelOn) begin
            checkOutput("model",
                {4'd0, rcolor_o, gcolor_o, bcolor_o, valid, changed, locked},
                rst ? 32'd0 : {4'd0, expColor[0], expColor[1], expColor[2], expValid, expChanged, expLocked});
        end
    end

    task automatic doReset();
        @(posedge clk); #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic applyStimulus(input logic anV, input logic [7:0] dr, input logic [7:0] dg, input logic [7:0] db);
        @(posedge clk); #2 rst = 1'b1;
        an = anV;
        invLines = anV;
        dutyR = dr; dutyG = dg; dutyB = db;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Returns the number of negedges waited until valid, or -1 after a counted timeout.
    task automatic waitValid(input bit useB, input int budget, output int waited);
        waited = -1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if ((useB ? validB : valid) === 1'b1) begin
                waited = n;
                break;
            end
        end
        if (waited < 0) checkOutput(useB ? "validB timeout" : "valid timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic       anV;
        logic [7:0] dr, dg, db;
        logic [7:0] er, eg, eb;
    } vec_t;

    vec_t tbl[3];

    initial begin
        int w;
        tbl[0] = '{anV: 1'b0, dr: 8'h40, dg: 8'h80, db: 8'hC0, er: 8'h40, eg: 8'h80, eb: 8'hC0};
        tbl[1] = '{anV: 1'b0, dr: 8'h00, dg: 8'hFF, db: 8'h01, er: 8'h00, eg: 8'hFF, eb: 8'h01};
        tbl[2] = '{anV: 1'b1, dr: 8'h10, dg: 8'h20, db: 8'h30, er: 8'h10, eg: 8'h20, eb: 8'h30};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset state", {rcolor_o, gcolor_o, bcolor_o, 5'd0, valid, changed, locked}, 32'd0);
        #1 rst = 1'b0;
        modelOn = 1'b1;

        for (int i = 0; i < 3; i++) begin
            applyStimulus(tbl[i].anV, tbl[i].dr, tbl[i].dg, tbl[i].db);
            for (int v = 0; v < 3; v++) waitValid(1'b0, 400, w);
            checkOutput($sformatf("vec%0d red", i), {24'd0, rcolor_o}, {24'd0, tbl[i].er});
            checkOutput($sformatf("vec%0d green", i), {24'd0, gcolor_o}, {24'd0, tbl[i].eg});
            checkOutput($sformatf("vec%0d blue", i), {24'd0, bcolor_o}, {24'd0, tbl[i].eb});
            checkOutput($sformatf("vec%0d changed", i), {31'd0, changed}, 32'd0);
            checkOutput($sformatf("vec%0d locked", i), {31'd0, locked}, 32'd1);
        end

        // Lock on red 0x40, then switch to 0x50 at PWM phase 0x48 inside the next window.
        applyStimulus(1'b0, 8'h40, 8'h11, 8'h22);
        waitValid(1'b0, 400, w);
        waitValid(1'b0, 400, w);
        checkOutput("lock before change", {31'd0, locked}, 32'd1);
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            if (pwmCnt == 8'h48) break;
        end
        dutyR = 8'h50;
        waitValid(1'b0, 400, w);
        checkOutput("blend red", {24'd0, rcolor_o}, 32'h48);
        checkOutput("blend changed", {31'd0, changed}, 32'd1);
        checkOutput("blend locked", {31'd0, locked}, 32'd0);
        waitValid(1'b0, 400, w);
        checkOutput("new red", {24'd0, rcolor_o}, 32'h50);
        checkOutput("new changed", {31'd0, changed}, 32'd1);
        checkOutput("new locked", {31'd0, locked}, 32'd0);
        waitValid(1'b0, 400, w);
        checkOutput("relock changed", {31'd0, changed}, 32'd0);
        checkOutput("relock locked", {31'd0, locked}, 32'd1);

        // Asynchronous reset at win_cnt = 100, then the first valid must take a full window.
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            if (sampleIdx == 100) break;
        end
        #2 rst = 1'b1;
        #1;
        checkOutput("async reset outputs", {rcolor_o, gcolor_o, bcolor_o, 5'd0, valid, changed, locked}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        waitValid(1'b0, 400, w);
        checkOutput("first valid delay", w, 32'd257);

        // Randomized duty segments under each polarity, checked by the reference model.
        for (int blk = 0; blk < 2; blk++) begin
            applyStimulus(blk[0], 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            for (int seg = 0; seg < 6; seg++) begin
                repeat ($urandom_range(150, 800)) @(posedge clk);
                dutyR = 8'($urandom_range(0, 255));
                dutyG = 8'($urandom_range(0, 255));
                dutyB = 8'($urandom_range(0, 255));
            end
            repeat (600) @(posedge clk);
        end

        // DIV = 4 with a 1024-clk PWM period.
        @(posedge clk); #2 rstB = 1'b0;
        waitValid(1'b1, 1500, w);
        waitValid(1'b1, 1500, w);
        checkOutput("div4 spacing 1", w, 32'd1024);
        checkOutput("div4 red 1", {24'd0, rcB}, 32'h33);
        waitValid(1'b1, 1500, w);
        checkOutput("div4 spacing 2", w, 32'd1024);
        checkOutput("div4 red 2", {24'd0, rcB}, 32'h33);
        checkOutput("div4 locked", {31'd0, lockedB}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
